// File: rtl/iv_bus_port.sv
// iv_bus_port: IV-bus transaction sequencer in front of the shift/merge stage.
// For each accepted command it strobes select, then reads a byte from the IV
// bus. The raw byte goes out on merge_in_o and a right-rotated copy goes out
// on shift_in_o. For read-modify-write commands it then waits MERGE_LAT
// cycles, captures merge_out_i and writes that value back. Each read or write
// strobe is held until iv_ack_i arrives, or until TIMEOUT cycles have passed,
// at which point the command is aborted.
// Ports:
//   clk_i, rst_i                  clock; asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake (ready only when idle)
//   cmd_write_i, cmd_bank_i,
//   cmd_addr_i, cmd_rot_i         command fields, latched on accept
//   iv_bank_o, iv_addr_o          held for the whole transaction
//   iv_sc_o, iv_rd_o, iv_wr_o     registered, mutually exclusive bus strobes
//   iv_dout_oe_o, iv_dout_o       write data and its drive enable
//   iv_din_i, iv_ack_i            read data and device acknowledge
//   shift_in_o, merge_in_o        rotated and raw read byte
//   merge_out_i                   result from the shift/merge stage
//   done_o, err_o                 one-cycle completion pulse; err_o=1 on timeout
module iv_bus_port #(
  parameter int TIMEOUT   = 16,
  parameter int MERGE_LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_write_i,
  input  logic       cmd_bank_i,
  input  logic [7:0] cmd_addr_i,
  input  logic [2:0] cmd_rot_i,
  output logic       iv_bank_o,
  output logic [7:0] iv_addr_o,
  output logic       iv_sc_o,
  output logic       iv_rd_o,
  output logic       iv_wr_o,
  output logic       iv_dout_oe_o,
  output logic [7:0] iv_dout_o,
  input  logic [7:0] iv_din_i,
  input  logic       iv_ack_i,
  output logic [7:0] shift_in_o,
  output logic [7:0] merge_in_o,
  input  logic [7:0] merge_out_i,
  output logic       done_o,
  output logic       err_o
);

  // One counter serves two purposes. It measures the strobe timeout in the
  // READ and WRITE states, and it counts the merge wait in the MERGE state.
  localparam int CMAX = (TIMEOUT > MERGE_LAT) ? TIMEOUT : MERGE_LAT;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_READ, S_MERGE, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [2:0]      rot_q, rot_d;
  logic            bank_q, bank_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      merge_q, merge_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      dout_q, dout_d;
  logic            err_d;
  logic            sc_q, rd_q, wr_q, done_q, err_q;

  function automatic logic [7:0] ror8(input logic [7:0] b, input logic [2:0] r);
    logic [15:0] t;
    t = {b, b} >> r;
    return t[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    rot_d   = rot_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    merge_d = merge_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        write_d = cmd_write_i;
        rot_d   = cmd_rot_i;
        bank_d  = cmd_bank_i;
        addr_d  = cmd_addr_i;
        state_d = S_SELECT;
      end
      S_SELECT: begin
        cnt_d   = '0;
        state_d = S_READ;
      end
      S_READ: begin
        // An ack on the expiry edge still counts as success.
        if (iv_ack_i) begin
          merge_d = iv_din_i;
          shift_d = ror8(iv_din_i, rot_q);
          cnt_d   = '0;
          state_d = write_q ? S_MERGE : S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MERGE: begin
        if (cnt_q == CW'(MERGE_LAT - 1)) begin
          dout_d  = merge_out_i;
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (iv_ack_i) begin
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The strobe and pulse outputs are registered and decoded from the next
  // state. They therefore line up exactly with the state they belong to, and
  // the asynchronous reset drops them at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      rot_q   <= '0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      merge_q <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      sc_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      rot_q   <= rot_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      sc_q    <= (state_d == S_SELECT);
      rd_q    <= (state_d == S_READ);
      wr_q    <= (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign iv_bank_o    = bank_q;
  assign iv_addr_o    = addr_q;
  assign iv_sc_o      = sc_q;
  assign iv_rd_o      = rd_q;
  assign iv_wr_o      = wr_q;
  assign iv_dout_oe_o = wr_q;
  assign iv_dout_o    = dout_q;
  assign shift_in_o   = shift_q;
  assign merge_in_o   = merge_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
